mem_port_arbiter: RTL and testbench

- Shares the single-port data SRAM between two requesters:
  - the MEM-stage data port (loads and stores);
  - the IF-stage instruction fetch port (reads only).
- Grants at most one access per cycle. Data has priority, with a bounded-starvation guarantee for fetch.
- Routes the synchronous-read response back to the requester that issued the read.
- Sits between the pipeline stages and the Sram instance. Requesters stall on a missing grant.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port data SRAM between the MEM-stage data port
// and the IF-stage fetch port. Data has priority; fetch is forced through after
// STARVE_LIMIT consecutive data grants made while it waits. The synchronous-read
// response is steered back to whichever requester issued the read.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned CNT_W        = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        d_req,
   input  logic [1:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        sram_read,
   output logic [1:0]  sram_write,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DATA = 2'd1;
   localparam logic [1:0] OWN_INST = 2'd2;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic [1:0]       rsp_owner;
   logic             starved;
   logic             d_load;

   assign starved = (starve_cnt == LIMIT);
   assign d_load  = (d_we == 2'b00);

   // Grant selection: data wins unless fetch has waited STARVE_LIMIT data grants
   always_comb begin
      d_gnt = 1'b0;
      i_gnt = 1'b0;
      if (!rst) begin
         if (d_req && i_req) begin
            d_gnt = !starved;
            i_gnt = starved;
         end else begin
            d_gnt = d_req;
            i_gnt = i_req;
         end
      end
   end

   // SRAM port mux driven by the granted requester; idle drives zeros
   always_comb begin
      sram_read  = 1'b0;
      sram_write = 2'b00;
      sram_addr  = '0;
      sram_wdata = '0;
      if (d_gnt) begin
         sram_read  = d_load;
         sram_write = d_we;
         sram_addr  = d_addr;
         sram_wdata = d_wdata;
      end else if (i_gnt) begin
         sram_read  = 1'b1;
         sram_addr  = i_addr;
      end
   end

   // Count data grants taken while fetch waits, saturating at the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (i_gnt || !i_req) begin
         starve_cnt <= '0;
      end else if (d_gnt && !starved) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Track which requester owns the read data returning next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_owner <= OWN_NONE;
      end else if (d_gnt && d_load) begin
         rsp_owner <= OWN_DATA;
      end else if (i_gnt) begin
         rsp_owner <= OWN_INST;
      end else begin
         rsp_owner <= OWN_NONE;
      end
   end

   // Steer SRAM read data to its owner; rst drops a response still in flight
   always_comb begin
      d_rvalid = !rst && (rsp_owner == OWN_DATA);
      i_rvalid = !rst && (rsp_owner == OWN_INST);
      d_rdata  = d_rvalid ? sram_rdata : '0;
      i_rdata  = i_rvalid ? sram_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous SRAM.
// Each step drives inputs on the falling edge, checks last cycle's response
// against a scoreboard entry, checks grants/SRAM drive, then queues the
// expected response of this cycle's grant.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        d_req = 1'b0;
   logic [1:0]  d_we = 2'b00;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        sram_read;
   logic [1:0]  sram_write;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  kind;   // 0 none, 1 data, 2 fetch
      logic [31:0] data;
   } rsp_t;

   rsp_t sb[$];

   logic        init = 1'b1;
   logic [31:0] mem [0:255];
   logic [7:0]  idx;

   assign idx        = sram_addr[9:2];
   assign sram_rdata = rdata_q;

   logic [31:0] rdata_q;

   always #5 clk = ~clk;

   // Behavioural SRAM: byte-lane writes, read data registered one cycle later
   always @(posedge clk) begin
      if (init) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k * 4);
         rdata_q <= '0;
      end else begin
         case (sram_write)
            2'b01: mem[idx][8*sram_addr[1:0] +: 8]  <= sram_wdata[7:0];
            2'b10: mem[idx][16*sram_addr[1] +: 16]  <= sram_wdata[15:0];
            2'b11: mem[idx]                         <= sram_wdata;
            default: ;
         endcase
         if (sram_read) rdata_q <= mem[idx];
      end
   end

   mem_port_arbiter #(.STARVE_LIMIT(3), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .i_req(i_req), .i_addr(i_addr),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .sram_read(sram_read), .sram_write(sram_write),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rs, input logic dr, input logic [1:0] we,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic ir, input logic [31:0] ia,
                       input logic eg_d, input logic eg_i, input logic [31:0] erd);
      rsp_t e;
      rsp_t n;
      @(negedge clk);
      rst = rs; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
      i_req = ir; i_addr = ia;
      #1;
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.kind = 2'd0;
         e.data = '0;
      end
      if (rs) e.kind = 2'd0;
      chk("d_rvalid", 32'(d_rvalid), 32'(e.kind == 2'd1));
      chk("i_rvalid", 32'(i_rvalid), 32'(e.kind == 2'd2));
      chk("d_rdata", d_rdata, (e.kind == 2'd1) ? e.data : 32'h0);
      chk("i_rdata", i_rdata, (e.kind == 2'd2) ? e.data : 32'h0);
      chk("d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("i_gnt", 32'(i_gnt), 32'(eg_i));
      chk("sram_read", 32'(sram_read), 32'((eg_d && we == 2'b00) || eg_i));
      chk("sram_write", 32'(sram_write), eg_d ? 32'(we) : 32'h0);
      chk("sram_addr", sram_addr, eg_d ? da : (eg_i ? ia : 32'h0));
      if (!eg_i) chk("sram_wdata", sram_wdata, eg_d ? wd : 32'h0);
      n.kind = (eg_d && we == 2'b00) ? 2'd1 : (eg_i ? 2'd2 : 2'd0);
      n.data = erd;
      sb.push_back(n);
   endtask

   initial begin
      // reset with both requesters active: nothing may be granted
      step(1, 1, 2'b11, 32'h10, 32'h1, 1, 32'h0, 0, 0, 0);
      step(1, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
      init = 1'b0;
      step(1, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
      chk("cnt_after_reset", 32'(dut.starve_cnt), 32'h0);

      // word store then load of the same address
      step(0, 1, 2'b11, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, 0, 0);
      step(0, 1, 2'b00, 32'h10, 32'h0, 0, 32'h0, 1, 0, 32'hDEADBEEF);
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);

      // back-to-back fetches from preloaded memory
      step(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, 1, 32'h1000_0000);
      step(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h4, 0, 1, 32'h1000_0004);
      step(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h8, 0, 1, 32'h1000_0008);
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);

      // both requesting: D, D, D, I repeating
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            step(0, 1, 2'b00, 32'h10, 32'h0, 1, 32'h0, k < 3, k == 3,
                 (k < 3) ? 32'hDEADBEEF : 32'h1000_0000);
            chk("starve_cnt", 32'(dut.starve_cnt), 32'(k));
         end
      end
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
      chk("cnt_idle", 32'(dut.starve_cnt), 32'h0);

      // sub-word stores merge into the existing word
      step(0, 1, 2'b01, 32'h21, 32'h0000_00AB, 0, 32'h0, 1, 0, 0);
      step(0, 1, 2'b00, 32'h20, 32'h0, 0, 32'h0, 1, 0, 32'h1000_AB20);
      step(0, 1, 2'b10, 32'h32, 32'h0000_BEEF, 0, 32'h0, 1, 0, 0);
      step(0, 1, 2'b00, 32'h30, 32'h0, 0, 32'h0, 1, 0, 32'hBEEF_0030);
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);

      // fetch in flight when reset hits: response dropped, counter cleared
      step(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h4, 0, 1, 32'h1000_0004);
      step(1, 1, 2'b00, 32'h10, 32'h0, 1, 32'h8, 0, 0, 0);
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
      chk("cnt_post_reset", 32'(dut.starve_cnt), 32'h0);

      // store grant followed directly by a fetch of the stored word
      step(0, 1, 2'b11, 32'h40, 32'h1234_5678, 0, 32'h0, 1, 0, 0);
      step(0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h40, 0, 1, 32'h1234_5678);
      step(0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
